etapa_decodificacion: RTL and testbench

ETAPA_DECODIFICACION -- requirements
Module: etapa_decodificacion

---
 rtl/pkg_procesador.sv | 35 +++
 rtl/banco_registros.sv | 46 ++++
 rtl/etapa_decodificacion.sv | 132 +++++++++++++
 tb/tb_etapa_decodificacion.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_procesador.sv
// Shared processor definitions: opcodes, ALU op codes, decode-stage state
// and the decode-to-execute bundle.
package pkg_procesador;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic {
    VACIA   = 1'b0,
    OCUPADA = 1'b1
  } estado_e;

  typedef struct packed {
    logic [31:0] val_a;
    logic [31:0] val_b;
    alu_op_e     op;
    logic [4:0]  rd;
    logic        esc_reg;
    logic        ilegal;
  } id_ex_t;

endpackage

// File: rtl/banco_registros.sv
// 32x32 register bank, x0 hardwired to zero, two async reads, one sync write.
// Same-cycle write bypass enabled by ETAPA_DECODIFICACION_ADELANTO_EN.
module banco_registros (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  dir_a,
  input  logic [4:0]  dir_b,
  output logic [31:0] dato_a,
  output logic [31:0] dato_b,
  input  logic        esc_hab,
  input  logic [4:0]  esc_dir,
  input  logic [31:0] esc_dato
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        fwd_a;
  logic        fwd_b;

  always_comb begin
    regs_d = regs_q;
    if (esc_hab && esc_dir != 5'd0)
      regs_d[esc_dir] = esc_dato;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      regs_q <= '{default: '0};
    else
      regs_q <= regs_d;
  end

`ifdef ETAPA_DECODIFICACION_ADELANTO_EN
  assign fwd_a = esc_hab && (esc_dir == dir_a);
  assign fwd_b = esc_hab && (esc_dir == dir_b);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign dato_a = (dir_a == 5'd0) ? '0 :
                  fwd_a ? esc_dato : regs_q[dir_a];
  assign dato_b = (dir_b == 5'd0) ? '0 :
                  fwd_b ? esc_dato : regs_q[dir_b];

endmodule

// File: rtl/etapa_decodificacion.sv
// RV32I decode stage for R-type and I-type ALU ops, with stall/flush.
// Optional writeback bypass via ETAPA_DECODIFICACION_ADELANTO_EN.
module etapa_decodificacion
  import pkg_procesador::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valida,
  input  logic [31:0] instruccion,
  output logic        instr_lista,
  input  logic        detener,
  input  logic        vaciar,
  input  logic        esc_hab,
  input  logic [4:0]  esc_rd,
  input  logic [31:0] esc_dato,
  output logic [31:0] valA,
  output logic [31:0] valB,
  output logic [3:0]  operacion,
  output logic [4:0]  rd,
  output logic        esc_reg,
  output logic        salida_valida,
  output logic        instr_ilegal
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd_i;
  logic [31:0] dato_a;
  logic [31:0] dato_b;
  logic        legal;
  logic        shift;
  id_ex_t      dec;
  id_ex_t      sal_d;
  id_ex_t      sal_q;
  estado_e     estado_d;
  estado_e     estado_q;

  assign opcode = instruccion[6:0];
  assign rd_i   = instruccion[11:7];
  assign f3     = instruccion[14:12];
  assign rs1    = instruccion[19:15];
  assign rs2    = instruccion[24:20];
  assign f7     = instruccion[31:25];
  assign shift  = (f3 == 3'b001) || (f3 == 3'b101);

  banco_registros u_banco (
    .clk      (clk),
    .rst_n    (rst_n),
    .dir_a    (rs1),
    .dir_b    (rs2),
    .dato_a   (dato_a),
    .dato_b   (dato_b),
    .esc_hab  (esc_hab),
    .esc_dir  (esc_rd),
    .esc_dato (esc_dato)
  );

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    unique case (1'b1)
      (opcode == OP_R): begin
        legal = (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) &&
                 ((f3 == 3'b000) || (f3 == 3'b101)));
        dec.val_a = dato_a;
        dec.val_b = dato_b;
        dec.op    = alu_op_e'({f7[5], f3});
      end
      (opcode == OP_I): begin
        legal = !shift || (f7 == 7'b0000000) ||
                (f7 == 7'b0100000);
        dec.val_a = dato_a;
        // shifts take only the 5-bit shamt as operand
        dec.val_b = shift ?
          {27'd0, instruccion[24:20]} :
          {{20{instruccion[31]}}, instruccion[31:20]};
        dec.op = (f3 == 3'b101) ?
          alu_op_e'({instruccion[30], 3'b101}) :
          alu_op_e'({1'b0, f3});
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      dec.rd      = rd_i;
      dec.esc_reg = (rd_i != 5'd0);
    end else begin
      dec        = '0;
      dec.ilegal = 1'b1;
    end
  end

  always_comb begin
    estado_d = estado_q;
    sal_d    = sal_q;
    if (vaciar) begin
      estado_d      = VACIA;
      sal_d.esc_reg = 1'b0;
    end else if (detener) begin
      estado_d = estado_q;
    end else if (instr_valida) begin
      estado_d = OCUPADA;
      sal_d    = dec;
    end else begin
      estado_d      = VACIA;
      sal_d.esc_reg = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= VACIA;
      sal_q    <= '0;
    end else begin
      estado_q <= estado_d;
      sal_q    <= sal_d;
    end
  end

  assign instr_lista   = !detener;
  assign valA          = sal_q.val_a;
  assign valB          = sal_q.val_b;
  assign operacion     = sal_q.op;
  assign rd            = sal_q.rd;
  assign esc_reg       = sal_q.esc_reg;
  assign instr_ilegal  = sal_q.ilegal;
  assign salida_valida = (estado_q == OCUPADA);

endmodule

// File: tb/tb_etapa_decodificacion.sv
// Self-checking bench for etapa_decodificacion: vector table plus
// stall/flush, bypass and mid-stream reset sequences.
module tb_etapa_decodificacion;

  typedef struct packed {
    logic [31:0] va;
    logic [31:0] vb;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        esc;
    logic        valida;
    logic        ilegal;
  } sal_t;

  typedef struct packed {
    sal_t s;
    logic solo_ctrl;
  } entrada_t;

  typedef struct {
    logic [31:0] instr;
    sal_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valida;
  logic [31:0] instruccion;
  logic        instr_lista;
  logic        detener;
  logic        vaciar;
  logic        esc_hab;
  logic [4:0]  esc_rd;
  logic [31:0] esc_dato;
  logic [31:0] valA;
  logic [31:0] valB;
  logic [3:0]  operacion;
  logic [4:0]  rd;
  logic        esc_reg;
  logic        salida_valida;
  logic        instr_ilegal;

  int n_tests = 0;
  int n_fail  = 0;
  entrada_t q[$];
  vec_t tabla[11];
  sal_t ult;
  sal_t burbuja;
  logic [31:0] exp_fwd;

  etapa_decodificacion dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valida  (instr_valida),
    .instruccion   (instruccion),
    .instr_lista   (instr_lista),
    .detener       (detener),
    .vaciar        (vaciar),
    .esc_hab       (esc_hab),
    .esc_rd        (esc_rd),
    .esc_dato      (esc_dato),
    .valA          (valA),
    .valB          (valB),
    .operacion     (operacion),
    .rd            (rd),
    .esc_reg       (esc_reg),
    .salida_valida (salida_valida),
    .instr_ilegal  (instr_ilegal)
  );

  always #5 clk = ~clk;

  function automatic sal_t mk(logic [31:0] va, logic [31:0] vb,
                              logic [3:0] op, logic [4:0] r,
                              logic e, logic v, logic il);
    sal_t s;
    s = {va, vb, op, r, e, v, il};
    return s;
  endfunction

  task automatic chk(string nom, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nom, act, exp);
    end
  endtask

  task automatic comparar(string nom);
    entrada_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nom);
    end else begin
      e = q.pop_front();
      chk({nom, ".valida"}, salida_valida, e.s.valida);
      chk({nom, ".esc_reg"}, esc_reg, e.s.esc);
      if (!e.solo_ctrl) begin
        chk({nom, ".valA"}, valA, e.s.va);
        chk({nom, ".valB"}, valB, e.s.vb);
        chk({nom, ".op"}, operacion, e.s.op);
        chk({nom, ".rd"}, rd, e.s.rd);
        chk({nom, ".ilegal"}, instr_ilegal, e.s.ilegal);
      end
    end
  endtask

  task automatic ciclo(string nom, sal_t exp, logic solo);
    q.push_back({exp, solo});
    @(posedge clk);
    #1;
    comparar(nom);
  endtask

  task automatic fijar(logic v, logic [31:0] ins, logic det, logic vac,
                       logic eh, logic [4:0] er, logic [31:0] ed);
    instr_valida = v;
    instruccion  = ins;
    detener      = det;
    vaciar       = vac;
    esc_hab      = eh;
    esc_rd       = er;
    esc_dato     = ed;
  endtask

  task automatic escribir(logic [4:0] r, logic [31:0] d);
    fijar(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, r, d);
    ciclo("wr", burbuja, 1'b1);
  endtask

  task automatic cero_salidas(string nom);
    chk({nom, ".valA"}, valA, 32'h0);
    chk({nom, ".valB"}, valB, 32'h0);
    chk({nom, ".op"}, operacion, 4'h0);
    chk({nom, ".rd"}, rd, 5'h0);
    chk({nom, ".esc_reg"}, esc_reg, 1'b0);
    chk({nom, ".valida"}, salida_valida, 1'b0);
    chk({nom, ".ilegal"}, instr_ilegal, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    burbuja = mk(0, 0, 0, 0, 0, 0, 0);
    tabla[0]  = '{32'h002081B3, mk(5, 3, 4'h0, 3, 1, 1, 0)};
    tabla[1]  = '{32'h402083B3, mk(5, 3, 4'h8, 7, 1, 1, 0)};
    tabla[2]  = '{32'h4020D213, mk(5, 2, 4'hD, 4, 1, 1, 0)};
    tabla[3]  = '{32'hFFF00293, mk(0, 32'hFFFFFFFF, 4'h0, 5, 1, 1, 0)};
    tabla[4]  = '{32'h00208033, mk(5, 3, 4'h0, 0, 0, 1, 0)};
    tabla[5]  = '{32'h00F17413, mk(3, 32'hF, 4'h7, 8, 1, 1, 0)};
    tabla[6]  = '{32'h00012083, mk(0, 0, 4'h0, 0, 0, 1, 1)};
    tabla[7]  = '{32'h4020C1B3, mk(0, 0, 4'h0, 0, 0, 1, 1)};
    tabla[8]  = '{32'h022081B3, mk(0, 0, 4'h0, 0, 0, 1, 1)};
    tabla[9]  = '{32'h02209213, mk(0, 0, 4'h0, 0, 0, 1, 1)};
    tabla[10] = '{32'h002094B3, mk(5, 3, 4'h1, 9, 1, 1, 0)};

    rst_n = 1'b0;
    fijar(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #12;
    cero_salidas("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    escribir(5'd1, 32'd5);
    escribir(5'd2, 32'd3);

    foreach (tabla[i]) begin
      fijar(1'b1, tabla[i].instr, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      #1;
      chk($sformatf("lista%0d", i), instr_lista, 1'b1);
      ciclo($sformatf("vec%0d", i), tabla[i].exp, 1'b0);
    end

    // stall freezes the accepted add, then flush under stall
    ult = mk(5, 3, 4'h0, 3, 1, 1, 0);
    fijar(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    ciclo("pre_stall", ult, 1'b0);
    for (int i = 0; i < 3; i++) begin
      fijar(1'b1, 32'h402083B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      #1;
      chk($sformatf("stall_lista%0d", i), instr_lista, 1'b0);
      ciclo($sformatf("stall%0d", i), ult, 1'b0);
    end
    fijar(1'b1, 32'h402083B3, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    ciclo("flush_stall", burbuja, 1'b1);
    fijar(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    ciclo("bubble", burbuja, 1'b1);
    fijar(1'b1, 32'h002081B3, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    ciclo("flush_accept", burbuja, 1'b1);

    // writeback bypass and x0 writes
    escribir(5'd1, 32'd7);
`ifdef ETAPA_DECODIFICACION_ADELANTO_EN
    exp_fwd = 32'hA5;
`else
    exp_fwd = 32'd7;
`endif
    fijar(1'b1, 32'h000081B3, 1'b0, 1'b0, 1'b1, 5'd1, 32'hA5);
    ciclo("bypass", mk(exp_fwd, 0, 4'h0, 3, 1, 1, 0), 1'b0);
    fijar(1'b1, 32'h001001B3, 1'b0, 1'b0, 1'b1, 5'd0, 32'h55);
    ciclo("x0_same", mk(0, 32'hA5, 4'h0, 3, 1, 1, 0), 1'b0);
    fijar(1'b1, 32'h000001B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    ciclo("x0_after", mk(0, 0, 4'h0, 3, 1, 1, 0), 1'b0);

    // asynchronous reset in the middle of a stream
    fijar(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    ciclo("pre_rst", mk(32'hA5, 3, 4'h0, 3, 1, 1, 0), 1'b0);
    fijar(1'b1, 32'h402083B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    cero_salidas("async_rst");
    @(posedge clk);
    #1;
    cero_salidas("rst_hold");
    rst_n = 1'b1;
    fijar(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    ciclo("post_rst", mk(0, 0, 4'h0, 3, 1, 1, 0), 1'b0);

    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
